ifu: RTL

Instruction fetch unit for the NPC core, directly upstream of `idu`. Owns the PC, issues one instruction-memory read at a time over a valid/ready request channel, and registers the returned word. Presents the word to `idu` through a valid/ready output handshake, and accepts PC redirects from the execute stage. One fetch is in flight at most; there is no prefetch.

---
 rtl/ifu_pkg.sv | 16 +
 rtl/ifu_pc.sv | 39 +++
 rtl/ifu.sv | 106 ++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width,
// FSM state encoding and the default reset PC.
package ifu_pkg;

  localparam int unsigned ISA_WIDTH       = 32;
  localparam int unsigned IFU_STATE_WIDTH = 2;

  localparam logic [ISA_WIDTH-1:0] PC_RESET_VAL = 32'h8000_0000;

  typedef enum logic [IFU_STATE_WIDTH-1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ifu_pc.sv
// PC register with next-PC selection (redirect > +4 > hold) and the
// word-alignment check used to suppress memory requests.
module ifu_pc
  import ifu_pkg::*;
#(
  parameter logic [ISA_WIDTH-1:0] RESET_PC = PC_RESET_VAL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 advance_i,
  input  logic                 redirect_valid_i,
  input  logic [ISA_WIDTH-1:0] redirect_pc_i,
  output logic [ISA_WIDTH-1:0] pc_o,
  output logic                 misaligned_o
);

  logic [ISA_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
    end else if (advance_i) begin
      pc_d = pc_q + ISA_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o         = pc_q;
  assign misaligned_o = |pc_q[1:0];

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: single outstanding imem request, registered
// instruction slot towards idu, redirect handling via a drop flag.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [ISA_WIDTH-1:0] RESET_PC = PC_RESET_VAL
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ISA_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [ISA_WIDTH-1:0] imem_rsp_data,
  input  logic                 imem_rsp_err,
  input  logic                 redirect_valid,
  input  logic [ISA_WIDTH-1:0] redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [ISA_WIDTH-1:0] inst,
  output logic [ISA_WIDTH-1:0] pc,
  output logic                 fetch_err,
  output logic [63:0]          fetch_cnt
);

  ifu_state_e           state_q;
  logic [ISA_WIDTH-1:0] inst_q;
  logic                 err_q;
  logic                 drop_q;
  logic [63:0]          cnt_q;
  logic                 misaligned;
  logic                 advance;

  assign advance = (state_q == IFU_HOLD) && inst_ready;

  ifu_pc #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk              (clk),
    .rst              (rst),
    .advance_i        (advance),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .pc_o             (pc),
    .misaligned_o     (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IFU_REQ;
      inst_q  <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IFU_REQ: begin
          // A redirect wins over the fault path; an accepted stale request must be dropped.
          if (redirect_valid) begin
            if (imem_req_valid && imem_req_ready) begin
              state_q <= IFU_WAIT;
              drop_q  <= 1'b1;
            end
          end else if (misaligned) begin
            inst_q  <= '0;
            err_q   <= 1'b1;
            state_q <= IFU_HOLD;
          end else if (imem_req_ready) begin
            state_q <= IFU_WAIT;
          end
        end
        IFU_WAIT: begin
          if (imem_rsp_valid) begin
            drop_q <= 1'b0;
            if (drop_q || redirect_valid) begin
              state_q <= IFU_REQ;
            end else begin
              inst_q  <= imem_rsp_err ? '0 : imem_rsp_data;
              err_q   <= imem_rsp_err;
              state_q <= IFU_HOLD;
            end
          end else if (redirect_valid) begin
            drop_q <= 1'b1;
          end
        end
        IFU_HOLD: begin
          if (inst_ready) begin
            cnt_q <= cnt_q + 64'd1;
          end
          if (inst_ready || redirect_valid) begin
            state_q <= IFU_REQ;
          end
        end
        default: state_q <= IFU_REQ;
      endcase
    end
  end

  assign imem_req_valid = (state_q == IFU_REQ) && !misaligned;
  assign imem_req_addr  = pc;
  assign inst_valid     = (state_q == IFU_HOLD);
  assign inst           = inst_q;
  assign fetch_err      = err_q;
  assign fetch_cnt      = cnt_q;

endmodule
